// File: rtl/ram_pkg.sv
// Shared definitions for the wait-stated byte-addressable RAM.
// Holds the MS size encodings, the controller FSM state type and two
// small helpers that decode an access size and detect illegal/misaligned
// requests.
package ram_pkg;

    // MS_2_0[1:0] size encodings; MS_2_0[2] separately requests sign extension.
    localparam logic [1:0] MS_BYTE    = 2'b00;
    localparam logic [1:0] MS_HALF    = 2'b01;
    localparam logic [1:0] MS_WORD    = 2'b10;
    localparam logic [1:0] MS_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAccess,
        StDone
    } ram_state_e;

    // Number of bytes moved by an access of the given size (0 for illegal).
    function automatic logic [2:0] ms_nbytes(input logic [1:0] ms);
        case (ms)
            MS_BYTE: return 3'd1;
            MS_HALF: return 3'd2;
            MS_WORD: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // True when the request must complete with Fault and no array access.
    function automatic logic ms_fault(input logic [1:0] ms, input logic [1:0] addr_lo);
        case (ms)
            MS_BYTE: return 1'b0;
            MS_HALF: return addr_lo[0];
            MS_WORD: return addr_lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/ram_bank.sv
// One byte lane of the RAM: a Depth x 8 array with synchronous write and
// combinational read of the addressed row.
// Ports:
//   clk_i   - clock; writes take effect on the rising edge
//   we_i    - write enable for this lane
//   row_i   - row address
//   wdata_i - byte to write
//   rdata_o - byte currently stored at row_i
module ram_bank #(
    parameter int unsigned RowW  = 6,
    parameter int unsigned Depth = 64
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [RowW-1:0] row_i,
    input  logic [7:0]      wdata_i,
    output logic [7:0]      rdata_o
);

    // No reset: contents survive Reset_n of the controller.
    logic [7:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[row_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[row_i];

endmodule

// File: rtl/ram_byte_ws.sv
// Byte-addressable RAM with a MOV/MOC handshake and configurable wait states.
// A request is captured in IDLE, optionally delayed WAIT_STATES cycles, then
// performed in a single ACCESS cycle; misaligned or illegal requests skip the
// array and complete one edge after capture with Fault set.
// Ports:
//   Clk, Reset_n   - clock and asynchronous active-low reset
//   MOV            - operation request (must drop for a cycle between requests)
//   ReadWrite      - 1 read, 0 write
//   MS_2_0         - [1:0] size (byte/half/word), [2] sign-extend reads
//   Address        - byte address, only [ADDR_W-1:0] used
//   DataIn         - right-justified write data
//   MOCoff         - ends a completed operation while MOV is still high
//   MOC            - operation complete
//   DataOut        - registered read data
//   Fault          - completed operation was misaligned or illegal
module ram_byte_ws
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_STATES = 2,
    parameter bit          BIG_ENDIAN  = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        MOV,
    input  logic        ReadWrite,
    input  logic [2:0]  MS_2_0,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    input  logic        MOCoff,
    output logic        MOC,
    output logic [31:0] DataOut,
    output logic        Fault
);

    localparam int unsigned RowW  = (ADDR_W > 2) ? ADDR_W - 2 : 1;
    localparam int unsigned Depth = 2 ** (ADDR_W - 2);

    ram_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              moc_q, moc_d;
    logic              fault_q, fault_d;
    logic [31:0]       dout_q, dout_d;
    // Set when DONE is left via MOCoff with MOV still high; blocks re-capture.
    logic              block_q, block_d;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        ms_q;
    logic [31:0]       din_q;
    logic              rd_q;
    logic              capture;

    logic [7:0]        lane_rdata [4];
    logic [7:0]        lane_wdata [4];
    logic [3:0]        lane_sel;
    logic [3:0]        bank_we;
    logic [1:0]        lane_idx;
    int                byte_pos;
    int                nbytes;
    logic [RowW-1:0]   row;
    logic [31:0]       rd_raw, rd_data;

    logic              unused_addr;
    assign unused_addr = ^(Address >> ADDR_W);

    assign capture = (state_q == StIdle) && MOV && !block_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            moc_q   <= 1'b0;
            fault_q <= 1'b0;
            dout_q  <= '0;
            block_q <= 1'b0;
            addr_q  <= '0;
            ms_q    <= '0;
            din_q   <= '0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            moc_q   <= moc_d;
            fault_q <= fault_d;
            dout_q  <= dout_d;
            block_q <= block_d;
            if (capture) begin
                addr_q <= Address[ADDR_W-1:0];
                ms_q   <= MS_2_0;
                din_q  <= DataIn;
                rd_q   <= ReadWrite;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        moc_d   = moc_q;
        fault_d = fault_q;
        dout_d  = dout_q;
        block_d = block_q;
        case (state_q)
            StIdle: begin
                if (!MOV) begin
                    block_d = 1'b0;
                end
                if (capture) begin
                    fault_d = 1'b0;
                    if (ms_fault(MS_2_0[1:0], Address[1:0])) begin
                        state_d = StDone;
                    end else if (WAIT_STATES == 0) begin
                        state_d = StAccess;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StAccess;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAccess: begin
                state_d = StDone;
                moc_d   = 1'b1;
                if (rd_q) begin
                    dout_d = rd_data;
                end
            end
            StDone: begin
                // MOC still low here only on the fault path, one edge after capture.
                if (!moc_q) begin
                    moc_d   = 1'b1;
                    fault_d = 1'b1;
                end else if (!MOV || MOCoff) begin
                    moc_d   = 1'b0;
                    state_d = StIdle;
                    block_d = MOV;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Map each byte of the access onto its lane; byte_pos is the byte's
    // position within the right-justified data word.
    always_comb begin
        nbytes   = int'(ms_nbytes(ms_q[1:0]));
        lane_sel = '0;
        rd_raw   = '0;
        lane_idx = '0;
        byte_pos = 0;
        for (int i = 0; i < 4; i++) begin
            lane_wdata[i] = '0;
        end
        for (int i = 0; i < 4; i++) begin
            if (i < nbytes) begin
                lane_idx              = addr_q[1:0] + 2'(i);
                byte_pos              = BIG_ENDIAN ? nbytes - 1 - i : i;
                lane_sel[lane_idx]    = 1'b1;
                lane_wdata[lane_idx]  = din_q[8*byte_pos +: 8];
                rd_raw[8*byte_pos +: 8] = lane_rdata[lane_idx];
            end
        end
    end

    always_comb begin
        case (ms_q[1:0])
            MS_BYTE: rd_data = {{24{ms_q[2] & rd_raw[7]}}, rd_raw[7:0]};
            MS_HALF: rd_data = {{16{ms_q[2] & rd_raw[15]}}, rd_raw[15:0]};
            default: rd_data = rd_raw;
        endcase
    end

    assign bank_we = ((state_q == StAccess) && !rd_q) ? lane_sel : 4'b0000;

    if (ADDR_W > 2) begin : g_row
        assign row = addr_q[ADDR_W-1:2];
    end else begin : g_row_single
        assign row = '0;
    end

    for (genvar b = 0; b < 4; b++) begin : g_bank
        ram_bank #(
            .RowW  (RowW),
            .Depth (Depth)
        ) u_bank (
            .clk_i   (Clk),
            .we_i    (bank_we[b]),
            .row_i   (row),
            .wdata_i (lane_wdata[b]),
            .rdata_o (lane_rdata[b])
        );
    end

    assign MOC     = moc_q;
    assign Fault   = fault_q;
    assign DataOut = dout_q;

endmodule

// File: tb/tb_ram_byte_ws.sv
// Directed bench for ram_byte_ws: a big-endian and a little-endian instance
// share one stimulus stream; expected results come from a byte-array model
// and are queued per request, then popped when MOC rises.
module tb_ram_byte_ws;

    localparam int unsigned WS = 2;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        MOV;
    logic        ReadWrite;
    logic [2:0]  MS_2_0;
    logic [31:0] Address;
    logic [31:0] DataIn;
    logic        MOCoff;
    logic        moc_be, fault_be, moc_le, fault_le;
    logic [31:0] dout_be, dout_le;

    ram_byte_ws #(.ADDR_W(8), .WAIT_STATES(WS), .BIG_ENDIAN(1'b1)) dut_be (
        .Clk(Clk), .Reset_n(Reset_n), .MOV(MOV), .ReadWrite(ReadWrite), .MS_2_0(MS_2_0),
        .Address(Address), .DataIn(DataIn), .MOCoff(MOCoff), .MOC(moc_be),
        .DataOut(dout_be), .Fault(fault_be)
    );

    ram_byte_ws #(.ADDR_W(8), .WAIT_STATES(WS), .BIG_ENDIAN(1'b0)) dut_le (
        .Clk(Clk), .Reset_n(Reset_n), .MOV(MOV), .ReadWrite(ReadWrite), .MS_2_0(MS_2_0),
        .Address(Address), .DataIn(DataIn), .MOCoff(MOCoff), .MOC(moc_le),
        .DataOut(dout_le), .Fault(fault_le)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] be;
        logic [31:0] le;
        logic        fault;
        int          edges;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [7:0]  mem_be [256];
    logic [7:0]  mem_le [256];
    logic [31:0] last_be = '0;
    logic [31:0] last_le = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, want);
        end
    endtask

    function automatic int size_of(input logic [2:0] ms);
        case (ms[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit is_fault(input logic [2:0] ms, input logic [31:0] addr);
        return (ms[1:0] == 2'b11) || (ms[1:0] == 2'b01 && addr[0]) ||
               (ms[1:0] == 2'b10 && addr[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] model_read(input bit be, input logic [2:0] ms,
                                               input logic [31:0] addr);
        int          n;
        logic [31:0] raw;
        logic [7:0]  a;
        logic [7:0]  b;
        n   = size_of(ms);
        raw = '0;
        for (int i = 0; i < n; i++) begin
            a = addr[7:0] + 8'(i);
            b = be ? mem_be[a] : mem_le[a];
            if (be) raw = (raw << 8) | {24'h0, b};
            else    raw = raw | ({24'h0, b} << (8 * i));
        end
        if (n == 1 && ms[2] && raw[7])  raw = raw | 32'hFFFF_FF00;
        if (n == 2 && ms[2] && raw[15]) raw = raw | 32'hFFFF_0000;
        return raw;
    endfunction

    task automatic model_write(input logic [2:0] ms, input logic [31:0] addr,
                               input logic [31:0] data);
        int         n;
        logic [7:0] a;
        n = size_of(ms);
        for (int i = 0; i < n; i++) begin
            a         = addr[7:0] + 8'(i);
            mem_be[a] = data[8*(n-1-i) +: 8];
            mem_le[a] = data[8*i +: 8];
        end
    endtask

    // One request: queue the expectation, drive it, scramble inputs after
    // capture, wait (bounded) for MOC and compare; optionally keep MOV high.
    task automatic do_op(input string tag, input logic rw, input logic [2:0] ms,
                         input logic [31:0] addr, input logic [31:0] data, input bit hold);
        exp_t e;
        exp_t got;
        int   edges;
        bit   seen;
        e.fault = is_fault(ms, addr);
        e.edges = e.fault ? 1 : int'(WS) + 1;
        if (!e.fault && rw) begin
            last_be = model_read(1'b1, ms, addr);
            last_le = model_read(1'b0, ms, addr);
        end else if (!e.fault) begin
            model_write(ms, addr, data);
        end
        e.be = last_be;
        e.le = last_le;
        sb.push_back(e);

        @(negedge Clk);
        MOV = 1'b1; ReadWrite = rw; MS_2_0 = ms; Address = addr; DataIn = data; MOCoff = 1'b0;
        @(posedge Clk);
        #1;
        ReadWrite = ~rw;
        MS_2_0    = 3'($urandom);
        Address   = $urandom;
        DataIn    = $urandom;

        seen  = 1'b0;
        edges = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(posedge Clk);
            #1;
            if (moc_be) begin
                seen  = 1'b1;
                edges = k;
            end
        end
        got = sb.pop_front();
        check($sformatf("%s.moc_edges", tag), 32'(edges), 32'(got.edges));
        check($sformatf("%s.moc_le", tag), 32'(moc_le), 32'd1);
        check($sformatf("%s.fault_be", tag), 32'(fault_be), 32'(got.fault));
        check($sformatf("%s.fault_le", tag), 32'(fault_le), 32'(got.fault));
        check($sformatf("%s.dout_be", tag), dout_be, got.be);
        check($sformatf("%s.dout_le", tag), dout_le, got.le);
        if (!hold) begin
            @(negedge Clk);
            MOV = 1'b0;
            @(posedge Clk);
            #1;
            check($sformatf("%s.moc_drop", tag), 32'(moc_be), 32'd0);
        end
    endtask

    initial begin
        bit seen;
        Reset_n = 1'b0; MOV = 1'b0; ReadWrite = 1'b0; MS_2_0 = '0;
        Address = '0; DataIn = '0; MOCoff = 1'b0;
        #3;
        check("rst.moc", 32'(moc_be), 32'd0);
        check("rst.fault", 32'(fault_be), 32'd0);
        check("rst.dout_be", dout_be, 32'd0);
        check("rst.dout_le", dout_le, 32'd0);
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Word write, byte read: big-endian MSB lives at the lowest address.
        do_op("w_word10", 1'b0, 3'b010, 32'h10, 32'h1122_3344, 1'b0);
        do_op("r_byte10", 1'b1, 3'b000, 32'h10, 32'h0, 1'b0);
        check("r_byte10.const", dout_be, 32'h0000_0011);

        // Halfword with and without sign extension.
        do_op("w_half22", 1'b0, 3'b001, 32'h22, 32'h0000_80FF, 1'b0);
        do_op("r_half22_sx", 1'b1, 3'b101, 32'h22, 32'h0, 1'b0);
        check("r_half22_sx.const", dout_be, 32'hFFFF_80FF);
        do_op("r_half22_zx", 1'b1, 3'b001, 32'h22, 32'h0, 1'b0);
        check("r_half22_zx.const", dout_be, 32'h0000_80FF);
        do_op("r_byte23_sx", 1'b1, 3'b100, 32'h23, 32'h0, 1'b0);

        // Byte write changes only its own lane.
        do_op("w_byte11", 1'b0, 3'b000, 32'h11, 32'hFFFF_FF5A, 1'b0);
        do_op("r_word10", 1'b1, 3'b010, 32'h10, 32'h0, 1'b0);
        check("r_word10.const", dout_be, 32'h115A_3344);

        // Faults: no access, DataOut kept, memory untouched.
        do_op("f_word13", 1'b1, 3'b010, 32'h13, 32'h0, 1'b0);
        do_op("f_ms11", 1'b1, 3'b011, 32'h10, 32'h0, 1'b0);
        do_op("f_wword12", 1'b0, 3'b010, 32'h12, 32'hCAFE_BABE, 1'b0);
        do_op("f_whalf11", 1'b0, 3'b001, 32'h11, 32'h0000_BEEF, 1'b0);
        do_op("r_word10b", 1'b1, 3'b010, 32'h10, 32'h0, 1'b0);
        check("r_word10b.const", dout_be, 32'h115A_3344);

        // Sign bit ignored for words.
        do_op("w_word30", 1'b0, 3'b010, 32'h30, 32'h89AB_CDEF, 1'b0);
        do_op("r_word30_sx", 1'b1, 3'b110, 32'h30, 32'h0, 1'b0);
        check("r_word30_sx.const", dout_le, 32'h89AB_CDEF);

        // MOV held in DONE, MOCoff ends it, no retrigger until MOV drops.
        do_op("hold", 1'b1, 3'b010, 32'h30, 32'h0, 1'b1);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        check("hold.moc_stays", 32'(moc_be), 32'd1);
        @(negedge Clk);
        MOCoff = 1'b1;
        @(posedge Clk);
        #1;
        check("hold.mocoff_drop", 32'(moc_be), 32'd0);
        @(negedge Clk);
        MOCoff = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge Clk);
            #1;
            if (moc_be) seen = 1'b1;
        end
        check("hold.no_retrigger", 32'(seen), 32'd0);
        @(negedge Clk);
        MOV = 1'b0;
        @(posedge Clk);
        do_op("after_hold", 1'b1, 3'b000, 32'h31, 32'h0, 1'b0);

        // Reset mid-WAIT aborts a write.
        do_op("w_word40", 1'b0, 3'b010, 32'h40, 32'h0102_0304, 1'b0);
        do_op("r_word40", 1'b1, 3'b010, 32'h40, 32'h0, 1'b0);
        @(negedge Clk);
        MOV = 1'b1; ReadWrite = 1'b0; MS_2_0 = 3'b010; Address = 32'h40; DataIn = 32'hDEAD_BEEF;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        #1;
        check("rst_wait.moc", 32'(moc_be), 32'd0);
        check("rst_wait.dout_be", dout_be, 32'd0);
        check("rst_wait.dout_le", dout_le, 32'd0);
        check("rst_wait.fault", 32'(fault_be), 32'd0);
        MOV = 1'b0;
        last_be = '0;
        last_le = '0;
        @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        do_op("r_word40_kept", 1'b1, 3'b010, 32'h40, 32'h0, 1'b0);
        check("r_word40_kept.const", dout_be, 32'h0102_0304);

        // Upper address bits wrap; top aligned word is usable.
        do_op("w_wrap1fc", 1'b0, 3'b010, 32'h1FC, 32'hAABB_CCDD, 1'b0);
        do_op("r_byte_fc", 1'b1, 3'b000, 32'hFC, 32'h0, 1'b0);
        check("r_byte_fc.le_const", dout_le, 32'h0000_00DD);
        do_op("r_word_2fc", 1'b1, 3'b010, 32'h2FC, 32'h0, 1'b0);
        check("r_word_2fc.le_const", dout_le, 32'hAABB_CCDD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_byte_ws.md
RAM_BYTE_WS -- requirements
Module: ram_byte_ws

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning byte-address width; depth is 2**ADDR_W bytes, minimum 2.
REQ-002 SHALL have parameter WAIT_STATES, default 2, meaning idle cycles inserted before the array access; range 0-15.
REQ-003 SHALL have parameter BIG_ENDIAN, default 1: 1 = lowest address holds the most significant byte; 0 = little endian.
REQ-004 SHALL have port Clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 SHALL have port Reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port MOV, input, 1 bit: memory operation request.
REQ-007 SHALL have port ReadWrite, input, 1 bit: 1 = read, 0 = write.
REQ-008 SHALL have port MS_2_0, input, 3 bits: [1:0] 00 byte, 01 halfword, 10 word, 11 illegal; [2] = sign-extend reads.
REQ-009 SHALL have port Address, input, 32 bits: byte address; only bits [ADDR_W-1:0] are used, so upper bits wrap.
REQ-010 SHALL have port DataIn, input, 32 bits: write data, right-justified.
REQ-011 SHALL have port MOCoff, input, 1 bit: forces MOC low.
REQ-012 SHALL have port MOC, output, 1 bit: operation complete.
REQ-013 SHALL have port DataOut, output, 32 bits: registered read data.
REQ-014 SHALL have port Fault, output, 1 bit: the completed operation was misaligned or illegal.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, ACCESS and DONE.
REQ-016 In IDLE with MOV=1, SHALL capture Address, MS_2_0, DataIn and ReadWrite, and clear Fault.
REQ-017 From that capture, SHALL go to DONE with Fault=1 and no array access if MS_2_0[1:0]=11, if a halfword has Address[0]=1, or if a word has Address[1:0]!=00.
REQ-018 Otherwise, SHALL go to WAIT with counter=WAIT_STATES-1, or straight to ACCESS if WAIT_STATES=0.
REQ-019 In WAIT, SHALL decrement the counter and go to ACCESS on the cycle the counter is 0.
REQ-020 In ACCESS, SHALL perform the write or read in exactly one cycle, then enter DONE.
REQ-021 MOC SHALL rise exactly WAIT_STATES+1 rising edges after the capture edge; a fault sets MOC=1 on the edge immediately after capture.
REQ-022 In DONE, MOC SHALL stay 1 until MOV=0 or MOCoff=1 is sampled, then go to IDLE with MOC=0 on that edge.
REQ-023 MOCoff SHALL be ignored in IDLE, WAIT and ACCESS.
REQ-024 A new request SHALL only be accepted from IDLE, so MOV held high after DONE does not retrigger until MOV has been low for one cycle.
REQ-025 Input changes after capture SHALL NOT affect the operation in flight.
REQ-026 Reads SHALL assemble 1, 2 or 4 bytes per BIG_ENDIAN into DataOut[7:0], [15:0] or [31:0] respectively.
REQ-027 For byte and halfword reads, if MS_2_0[2]=1 the upper DataOut bits SHALL replicate the MSB of the assembled data; otherwise they SHALL be 0.
REQ-028 For word reads, MS_2_0[2] SHALL be ignored.
REQ-029 Writes SHALL store DataIn[7:0], [15:0] or [31:0] per BIG_ENDIAN, and only the addressed bytes SHALL change.
REQ-030 On writes and faults, DataOut SHALL be unchanged.
REQ-031 The highest aligned word SHALL be valid at addresses 2**ADDR_W-4 .. 2**ADDR_W-1; no access crosses the top boundary because alignment is enforced.

Reset
REQ-032 While Reset_n=0, SHALL force MOC=0, Fault=0, DataOut=0, state=IDLE and counter=0 immediately, without waiting for Clk.
REQ-033 Reset during WAIT SHALL abort the operation and commit no write.
REQ-034 Reset SHALL NOT initialise array contents.

Structure
REQ-035 SHALL define the MS size encodings (MS_BYTE, MS_HALF, MS_WORD) and the FSM state type in shared package ram_pkg.
REQ-036 SHALL store data as four instances of sub-module ram_bank, each a 2**(ADDR_W-2) x 8 synchronous array with per-bank write enable.
REQ-037 The bank SHALL be selected by byte lane and the row by Address[ADDR_W-1:2].

Verification
REQ-038 With WAIT_STATES=2: word write 0x11223344 to 0x10, then byte read 0x10 with MS=000 -> DataOut=0x00000011 (BE), MOC rising on the 3rd edge after capture.
REQ-039 Halfword write 0x80FF to 0x22, then halfword read with MS=101 -> DataOut=0xFFFF80FF; with MS=001 -> 0x000080FF.
REQ-040 Word read at 0x13 -> Fault=1 and MOC=1 one edge after capture, DataOut unchanged, memory unchanged; MS_2_0[1:0]=11 -> same response.
REQ-041 Hold MOV=1 in DONE, then pulse MOCoff -> MOC=0 next edge; no second operation until MOV drops for one cycle.
REQ-042 Assert Reset_n=0 mid-WAIT of a word write to 0x40 -> MOC=0 immediately; a later read of 0x40 returns its prior contents.
REQ-043 BIG_ENDIAN=0, ADDR_W=8: write 0xAABBCCDD to 0x1FC -> address 0xFC (wrapped) holds 0xDD.
